// File: rtl/matmul_ctrl.sv
// matmul_ctrl: job sequencer for the matmul_datapath MAC array.
// One accumulator clear, then K accumulate steps with k = 0..K-1, then a
// MAC_LAT-cycle drain, then c_valid held until the consumer takes C.
// Every output is decoded from registered state only.
module matmul_ctrl #(
  parameter int K       = 2,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               clear,
  output logic               en,
  output logic [$clog2(K):0] k,
  output logic               c_valid,
  input  logic               c_ready
);

  localparam int KW = $clog2(K) + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  // With no pipeline latency the drain state is never entered, so its
  // terminal count is irrelevant; pin it to 0 to keep the constant in range.
  localparam logic [DW-1:0] D_LAST = DW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam bit HAS_DRAIN = (MAC_LAT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // State and counter registers; reset lands in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and counter update; abort overrides everything, including start.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    dcnt_d  = dcnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          // kcnt only ever restarts here, so it never wraps by overflow.
          state_d = S_ACCUM;
          kcnt_d  = '0;
        end
        S_ACCUM: begin
          if (kcnt_q == K_LAST) begin
            if (HAS_DRAIN) begin
              state_d = S_DRAIN;
              dcnt_d  = '0;
            end else begin
              state_d = S_RESULT;
            end
          end else begin
            kcnt_d = kcnt_q + KW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == D_LAST) state_d = S_RESULT;
          else                  dcnt_d  = dcnt_q + DW'(1);
        end
        S_RESULT: begin
          if (c_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode from the state register and k counter.
  always_comb begin
    busy    = (state_q != S_IDLE);
    clear   = (state_q == S_CLEAR);
    en      = (state_q == S_ACCUM);
    c_valid = (state_q == S_RESULT);
    k       = (state_q == S_ACCUM) ? kcnt_q : '0;
  end

  // Datapath-interface invariants.
  a_clear_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(clear && en));
  a_en_starts_k0: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(en) |-> (k == '0));
  a_en_runs_on: assert property (@(posedge clk) disable iff (!rst_n)
    (en && (kcnt_q != K_LAST) && !abort) |=> en);
  a_en_stops: assert property (@(posedge clk) disable iff (!rst_n)
    (en && (kcnt_q == K_LAST)) |=> !en);
  a_k_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    en |-> (k <= K_LAST));
  a_cvalid_no_en: assert property (@(posedge clk) disable iff (!rst_n)
    c_valid |-> !en);
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state_q != S_IDLE));
  a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (c_valid && !c_ready && !abort) |=> (c_valid && !en && !clear && (k == '0)));

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
Sequencer for the matmul_datapath MAC array. On a start request it issues one accumulator clear, then steps the reduction index k from 0 to K-1 with en asserted, waits out the MAC pipeline latency, and holds a result-valid flag until the consumer accepts C. It sits between the AXI/register front end and the datapath, and is the only driver of the datapath's clear, en and k inputs.

Parameters:
K, 2, reduction depth; number of accumulate cycles per job; must be >= 1.
MAC_LAT, 1, cycles from the last en cycle until C is final; must be >= 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE from any state
busy  out  1  high in every state except IDLE
clear  out  1  accumulator clear to datapath
en  out  1  accumulate enable to datapath
k  out  $clog2(K)+1  reduction index to datapath; width matches the datapath k port
c_valid  out  1  C is final and stable
c_ready  in  1  consumer accepts C

Behaviour:
- Reset (async, rst_n=0): state=IDLE, k counter=0, drain counter=0; all outputs busy, clear, en, k, c_valid = 0 immediately, with no wait for clk.
- Outputs are Moore: decoded from registered state/counters only; no combinational path from start, c_ready or abort to any output.
- States and transitions:
  - IDLE: all outputs 0. start=1 -> CLEAR.
  - CLEAR: clear=1, en=0, k=0, for exactly 1 cycle -> ACCUM, with kcnt=0.
  - ACCUM: en=1, clear=0, k=kcnt. kcnt increments each cycle.
    - kcnt==K-1 and MAC_LAT>0 -> DRAIN (dcnt=0).
    - kcnt==K-1 and MAC_LAT==0 -> RESULT.
  - DRAIN: en=0, k=0. dcnt increments each cycle; dcnt==MAC_LAT-1 -> RESULT.
  - RESULT: c_valid=1, held until c_ready=1 is sampled; then -> IDLE. The job completes on the c_valid & c_ready cycle.
- Timing, with start sampled at edge E0:
  - clear high in cycle 1.
  - en high in cycles 2..K+1, with k=0..K-1.
  - DRAIN in cycles K+2..K+1+MAC_LAT.
  - c_valid rises in cycle K+2+MAC_LAT.
  - Minimum back-to-back period is K+3+MAC_LAT cycles: accept in RESULT, IDLE for 1 cycle, then start.
- start outside IDLE is ignored; there is no queuing.
- start and abort together in IDLE: abort wins and the FSM stays in IDLE.
- abort=1 in any state -> IDLE on the next edge. clear is not issued. c_valid drops. Accumulator contents are undefined afterward; the next job's CLEAR rescrubs them.
- c_ready while c_valid=0 is ignored.
- k is never >= K while en=1. The kcnt register wraps only through the CLEAR reload, never by overflow.
- Invariants, enforced as assertions:
  - clear and en are never both 1.
  - en is 1 for exactly K consecutive cycles per non-aborted job.
  - c_valid implies en=0.
  - busy==0 iff state==IDLE.
- Outputs stay stable while c_valid=1 and c_ready=0. This guarantees the datapath's C-stable-when-idle property.

Test Plan:
- Basic job, K=2, MAC_LAT=1, start pulse at E0, c_ready tied high -> clear=1 in cycle 1; en=1 in cycles 2-3 with k=0,1; en=0 in cycle 4; c_valid=1 in cycle 5 only; busy high in cycles 1-5. With datapath A={{1,2},{3,4}}, B={{5,6},{7,8}}: C={{19,22},{43,50}} when c_valid=1.
- Backpressure: c_ready=0 for 4 cycles after c_valid rises, then 1 -> c_valid held 5 cycles; en, clear, k stay 0; C unchanged; IDLE the cycle after acceptance.
- Ignored start and back-to-back jobs: start held high continuously -> second clear exactly K+3+MAC_LAT=6 cycles after the first; no start accepted mid-job; the second job's C is independent of the first (clear effective).
- Abort in ACCUM, abort=1 during the k=0 en cycle -> next cycle busy=0, en=0, no c_valid. A following start gives a full normal job with correct C.
- Async reset mid-DRAIN, rst_n low between edges -> busy, en, c_valid go to 0 before the next edge. After release, start runs a normal job.
- Corner parameters:
  - K=1, MAC_LAT=0: en for 1 cycle, c_valid in cycle 3.
  - K=4, MAC_LAT=2: en for 4 cycles with k=0..3, c_valid in cycle 8.
